// File: rtl/cache_pkg.sv
// Shared cache/memory-interface types: RAM handshake states and arbiter FSM states.
package cache_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arbstate_t;

    function automatic logic ram_done(input logic [1:0] rs);
        return rs == ACCESS;
    endfunction

endpackage

// File: rtl/arb_fair_counter.sv
// Saturating count of dcache grants issued while icache waits; 1-cycle update, no backpressure.
module arb_fair_counter #(
    parameter int LIMIT = 4,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX = W'(LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Dcache-first arbiter of icache/dcache word requests onto one RAM port; grant 1 cycle after request, waits held until ramstate==ACCESS.
// Optional MEMARB_STATS_EN adds completion and RAM-error counters.
module memory_arbiter
    import cache_pkg::*;
#(
    parameter int IFAIR_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
`ifdef MEMARB_STATS_EN
    ,
    output logic [31:0] icount,
    output logic [31:0] dcount,
    output logic [15:0] errcount
`endif
);

    localparam int FAIR_W = $clog2(IFAIR_LIMIT + 1);
    localparam logic [FAIR_W-1:0] FAIR_MAX = FAIR_W'(IFAIR_LIMIT);

    arbstate_t          state, state_nxt;
    logic [FAIR_W-1:0]  fair_cnt;
    logic               dreq, access, starving, fair_inc, fair_clr;

    assign dreq     = dREN | dWEN;
    assign access   = ram_done(ramstate);
    assign starving = (fair_cnt == FAIR_MAX) && iREN;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (dreq && !starving) state_nxt = DGRANT;
                else if (iREN)         state_nxt = IGRANT;
            end
            // A dropped request abandons the grant; ERROR/BUSY/FREE all hold it.
            DGRANT: if (access || !dreq) state_nxt = IDLE;
            IGRANT: if (access || !iREN) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nxt;
    end

    assign fair_inc = (state == IDLE) && (state_nxt == DGRANT) && iREN;
    assign fair_clr = (state == IDLE) && ((state_nxt == IGRANT) || !iREN);

    arb_fair_counter #(
        .LIMIT (IFAIR_LIMIT),
        .W     (FAIR_W)
    ) u_fair (
        .clk   (CLK),
        .rst_n (nRST),
        .inc   (fair_inc),
        .clr   (fair_clr),
        .cnt   (fair_cnt)
    );

    // RAM enables follow the live request so a mid-grant drop stops the access at once.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        unique case (state)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
            end
            IGRANT: begin
                ramaddr  = iaddr;
                ramREN   = iREN;
            end
            default: ;
        endcase
    end

    assign dwait = ~((state == DGRANT) && access);
    assign iwait = ~((state == IGRANT) && access);
    assign iload = ramload;
    assign dload = ramload;

`ifdef MEMARB_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icount   <= '0;
            dcount   <= '0;
            errcount <= '0;
        end else begin
            if ((state == IGRANT) && access) icount <= icount + 32'd1;
            if ((state == DGRANT) && access) dcount <= dcount + 32'd1;
            if ((state != IDLE) && (ramstate == ERROR)) errcount <= errcount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed cycle checks plus randomized scoreboard traffic against a RAM model.
module tb_memory_arbiter;

    localparam int LIMIT = 4;
    localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [1:0]  ramstate;
`ifdef MEMARB_STATS_EN
    logic [31:0] icount, dcount;
    logic [15:0] errcount;
`endif

    memory_arbiter #(.IFAIR_LIMIT(LIMIT)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
`ifdef MEMARB_STATS_EN
        , .icount(icount), .dcount(dcount), .errcount(errcount)
`endif
    );

    always #5 CLK = ~CLK;

    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // RAM model: 16 writable words at 0x3100.., everything else reads back 0xDEAD<addr>.
    logic [31:0] dmem   [16] = '{default: 32'h0};
    logic [31:0] refmem [16] = '{default: 32'h0};

    always_comb begin
        if (ramaddr[31:8] == 24'h000031) ramload = dmem[ramaddr[3:0]];
        else                             ramload = 32'hDEAD0000 | {16'h0, ramaddr[15:0]};
    end

    always @(posedge CLK) begin
        if (ramWEN && ramstate == RS_ACCESS) dmem[ramaddr[3:0]] <= ramstore;
    end

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];
    bit   mon_en   = 1'b0;
    bit   rand_done = 1'b0;

    always @(negedge CLK) begin
        exp_t e;
        if (mon_en && nRST) begin
            check("one_grant", {31'h0, !iwait && !dwait}, 32'h0);
            if (!iwait) begin
                if (iq.size() == 0) check("i_unexpected", 32'h0, 32'h1);
                else begin
                    e = iq.pop_front();
                    check("i_ramaddr", ramaddr, e.addr);
                    check("i_ramren", {31'h0, ramREN}, 32'h1);
                    check("iload", iload, e.data);
                end
            end
            if (!dwait) begin
                if (dq.size() == 0) check("d_unexpected", 32'h0, 32'h1);
                else begin
                    e = dq.pop_front();
                    check("d_ramaddr", ramaddr, e.addr);
                    check("d_ramwen", {31'h0, ramWEN}, {31'h0, e.wr});
                    check("d_ramren", {31'h0, ramREN}, {31'h0, !e.wr});
                    if (e.wr) check("d_ramstore", ramstore, e.data);
                    else      check("dload", dload, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic icache_driver(input int n);
        for (int k = 0; k < n; k++) begin
            int          gap;
            int          cyc;
            bit          done;
            logic [31:0] a;
            gap = $urandom_range(0, 3);
            repeat (gap) tick();
            a = 32'h100 + $urandom_range(0, 255);
            iaddr = a;
            iREN  = 1'b1;
            iq.push_back('{wr: 1'b0, addr: a, data: 32'hDEAD0000 | a});
            cyc = 0; done = 1'b0;
            while (!done && cyc < 200) begin
                @(negedge CLK);
                if (!iwait) done = 1'b1;
                cyc++;
            end
            if (!done) begin check("i_timeout", 32'h0, 32'h1); iq.delete(); end
            tick();
            iREN = 1'b0;
        end
    endtask

    task automatic dcache_driver(input int n);
        for (int k = 0; k < n; k++) begin
            int          gap;
            int          cyc;
            int          idx;
            bit          done;
            bit          wr;
            logic [31:0] d;
            gap = $urandom_range(0, 3);
            repeat (gap) tick();
            idx = $urandom_range(0, 15);
            wr  = 1'($urandom_range(0, 1));
            daddr = 32'h3100 + idx;
            if (wr) begin
                d = $urandom;
                refmem[idx] = d;
                dstore = d;
                dWEN = 1'b1;
                dREN = 1'($urandom_range(0, 1));
            end else begin
                d = refmem[idx];
                dstore = $urandom;
                dWEN = 1'b0;
                dREN = 1'b1;
            end
            dq.push_back('{wr: wr, addr: 32'h3100 + idx, data: d});
            cyc = 0; done = 1'b0;
            while (!done && cyc < 200) begin
                @(negedge CLK);
                if (!dwait) done = 1'b1;
                cyc++;
            end
            if (!done) begin check("d_timeout", 32'h0, 32'h1); dq.delete(); end
            tick();
            dREN = 1'b0;
            dWEN = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        byte  grants[$];
        int   cyc;
`ifdef MEMARB_STATS_EN
        logic [15:0] err0;
`endif
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramstate = RS_FREE;

        // Reset state
        @(negedge CLK);
        check("rst_ramren", {31'h0, ramREN}, 32'h0);
        check("rst_ramwen", {31'h0, ramWEN}, 32'h0);
        check("rst_ramaddr", ramaddr, 32'h0);
        check("rst_ramstore", ramstore, 32'h0);
        check("rst_iwait", {31'h0, iwait}, 32'h1);
        check("rst_dwait", {31'h0, dwait}, 32'h1);
        check("rst_iload", iload, 32'hDEAD0000);
        check("rst_dload", dload, 32'hDEAD0000);
        tick();
        nRST = 1'b1;
        ramstate = RS_ACCESS;
        tick();

        // Single icache fetch with zero-latency RAM
        iREN = 1'b1; iaddr = 32'h40;
        @(negedge CLK);
        check("t1_idle_iwait", {31'h0, iwait}, 32'h1);
        check("t1_idle_ramren", {31'h0, ramREN}, 32'h0);
        @(negedge CLK);
        check("t1_iwait", {31'h0, iwait}, 32'h0);
        check("t1_iload", iload, 32'hDEAD0040);
        check("t1_ramaddr", ramaddr, 32'h40);
        tick();
        iREN = 1'b0;

        // dREN+dWEN: write wins
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h3100; dstore = 32'h5; refmem[0] = 32'h5;
        @(negedge CLK);
        check("t2_idle_dwait", {31'h0, dwait}, 32'h1);
        @(negedge CLK);
        check("t2_ramwen", {31'h0, ramWEN}, 32'h1);
        check("t2_ramren", {31'h0, ramREN}, 32'h0);
        check("t2_ramstore", ramstore, 32'h5);
        check("t2_ramaddr", ramaddr, 32'h3100);
        check("t2_dwait", {31'h0, dwait}, 32'h0);
        tick();
        dREN = 1'b0; dWEN = 1'b0;

        // Simultaneous requests: dcache first, bubble, then icache
        iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h3100;
        @(negedge CLK);
        @(negedge CLK);
        check("t3_d_ramaddr", ramaddr, 32'h3100);
        check("t3_dwait", {31'h0, dwait}, 32'h0);
        check("t3_iwait_held", {31'h0, iwait}, 32'h1);
        check("t3_dload", dload, 32'h5);
        tick();
        dREN = 1'b0;
        @(negedge CLK);
        check("t3_bubble_ramren", {31'h0, ramREN}, 32'h0);
        @(negedge CLK);
        check("t3_i_ramaddr", ramaddr, 32'h44);
        check("t3_iwait", {31'h0, iwait}, 32'h0);
        check("t3_iload", iload, 32'hDEAD0044);
        tick();
        iREN = 1'b0;

        // BUSY x3, ERROR x2, then ACCESS
`ifdef MEMARB_STATS_EN
        err0 = errcount;
`endif
        dREN = 1'b1; daddr = 32'h3101; ramstate = RS_BUSY;
        @(negedge CLK);
        for (int k = 1; k <= 6; k++) begin
            tick();
            ramstate = (k <= 3) ? RS_BUSY : (k <= 5) ? RS_ERROR : RS_ACCESS;
            @(negedge CLK);
            check($sformatf("t4_dwait_c%0d", k), {31'h0, dwait}, {31'h0, k < 6});
        end
        check("t4_dload", dload, refmem[1]);
        tick();
        dREN = 1'b0;
`ifdef MEMARB_STATS_EN
        check("t4_errcount", {16'h0, errcount - err0}, 32'd2);
`endif
        ramstate = RS_ACCESS;
        tick();

        // Fairness: continuous requests from both caches
        iREN = 1'b1; iaddr = 32'h48; dREN = 1'b1; daddr = 32'h3102;
        cyc = 0;
        while (grants.size() < 10 && cyc < 60) begin
            @(negedge CLK);
            if (ramREN) grants.push_back((ramaddr == 32'h3102) ? byte'("D") : byte'("I"));
            cyc++;
        end
        check("t5_grant_count", grants.size(), 32'd10);
        for (int k = 0; k < grants.size(); k++)
            check($sformatf("t5_grant%0d", k), {24'h0, grants[k]},
                  {24'h0, ((k % (LIMIT + 1)) == LIMIT) ? byte'("I") : byte'("D")});
        tick();
        iREN = 1'b0; dREN = 1'b0;
        tick();

        // Reset pulsed mid-IGRANT
        ramstate = RS_BUSY; iREN = 1'b1; iaddr = 32'h4C;
        @(negedge CLK);
        @(negedge CLK);
        check("t6_granted_ramren", {31'h0, ramREN}, 32'h1);
        check("t6_granted_iwait", {31'h0, iwait}, 32'h1);
        #2 nRST = 1'b0;
        #1;
        check("t6_rst_ramren", {31'h0, ramREN}, 32'h0);
        check("t6_rst_ramaddr", ramaddr, 32'h0);
        check("t6_rst_iwait", {31'h0, iwait}, 32'h1);
        @(negedge CLK);
        #2 nRST = 1'b1; ramstate = RS_ACCESS;
        #1;
        check("t6_idle_ramren", {31'h0, ramREN}, 32'h0);
        @(negedge CLK);
        check("t6_regrant_ramaddr", ramaddr, 32'h4C);
        check("t6_regrant_iwait", {31'h0, iwait}, 32'h0);
        tick();
        iREN = 1'b0;
        tick();

        // Randomized traffic through the scoreboard
        mon_en = 1'b1;
        fork
            begin
                fork
                    icache_driver(60);
                    dcache_driver(60);
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    int r;
                    tick();
                    r = $urandom_range(0, 9);
                    ramstate = (r < 5) ? RS_ACCESS : (r < 8) ? RS_BUSY : (r < 9) ? RS_ERROR : RS_FREE;
                end
            end
        join
        repeat (2) tick();
        mon_en = 1'b0;
        check("iq_drained", iq.size(), 32'h0);
        check("dq_drained", dq.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
